// File: rtl/clock_pkg.sv
// Shared types, limits and BCD helpers for the alarm clock and its digit counters.
package clock_pkg;

  typedef logic [3:0] bcd_digit_t;
  typedef logic [7:0] bcd_pair_t;

  typedef enum logic [1:0] {IDLE, RINGING, SNOOZED} alarm_state_t;

  localparam bcd_pair_t MAX_SEC  = 8'h59;
  localparam bcd_pair_t MAX_MIN  = 8'h59;
  localparam bcd_pair_t MAX_HOUR = 8'h23;

  // With both digits <= 9, plain binary compare orders BCD pairs correctly.
  function automatic logic bcd_pair_ok(input bcd_pair_t v, input bcd_pair_t max);
    bcd_digit_t tens;
    bcd_digit_t units;
    tens  = v[7:4];
    units = v[3:0];
    return (tens <= 4'd9) && (units <= 4'd9) && (v <= max);
  endfunction

  function automatic bcd_pair_t hour_display(input bcd_pair_t h24, input logic mode24);
    logic [6:0] bin;
    bin = 7'(h24[7:4]) * 7'd10 + 7'(h24[3:0]);
    if (mode24) return h24;
    if (bin == 7'd0) return 8'h12;
    if (bin > 7'd12) bin = bin - 7'd12;
    return {4'(bin / 7'd10), 4'(bin % 7'd10)};
  endfunction

endpackage

// File: rtl/bcd_wrap_counter.sv
// Two-digit BCD counter wrapping MAX -> 00; load wins over inc, carry flags the wrap.
module bcd_wrap_counter
  import clock_pkg::*;
#(
  parameter bcd_pair_t MAX = 8'h59
) (
  input  logic      clk,
  input  logic      reset,
  input  logic      inc,
  input  logic      load,
  input  bcd_pair_t load_val,
  output bcd_pair_t q,
  output bcd_pair_t nxt,
  output logic      carry
);

  bcd_pair_t cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load) begin
      cnt_d = load_val;
    end else if (inc) begin
      if (cnt_q == MAX)             cnt_d = '0;
      else if (cnt_q[3:0] == 4'd9)  cnt_d = {cnt_q[7:4] + 4'd1, 4'd0};
      else                          cnt_d = {cnt_q[7:4], cnt_q[3:0] + 4'd1};
    end
  end

  always_ff @(posedge clk) begin
    if (reset) cnt_q <= '0;
    else       cnt_q <= cnt_d;
  end

  assign q     = cnt_q;
  assign nxt   = cnt_d;
  assign carry = inc && !load && (cnt_q == MAX);

endmodule

// File: rtl/bcd_alarm_clock.sv
// 24 h BCD timekeeper with prescaler, 12/24 h display, and a ring/snooze alarm FSM.
module bcd_alarm_clock
  import clock_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1,
  parameter int unsigned SNOOZE_SEC = 300,
  parameter int unsigned RING_SEC   = 60
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       ena,
  input  logic       mode24,
  input  logic       set_time,
  input  logic [7:0] set_hh,
  input  logic [7:0] set_mm,
  input  logic [7:0] set_ss,
  input  logic       alarm_wr,
  input  logic [7:0] alarm_hh,
  input  logic [7:0] alarm_mm,
  input  logic       alarm_on,
  input  logic       snooze,
  input  logic       stop,
  output logic [7:0] hh,
  output logic [7:0] mm,
  output logic [7:0] ss,
  output logic       pm,
  output logic       sec_tick,
  output logic       ringing
);

  localparam logic [23:0] DIV_LAST  = 24'(CLK_DIV - 1);
  localparam logic [31:0] SNOOZE_LD = 32'(SNOOZE_SEC);
  localparam logic [31:0] RING_LD   = 32'(RING_SEC);

  logic [23:0]  presc_q, presc_d;
  bcd_pair_t    alarm_hh_q, alarm_hh_d, alarm_mm_q, alarm_mm_d;
  alarm_state_t state_q, state_d;
  logic [31:0]  cnt_q, cnt_d;
  logic         tick_dly_q, tick_dly_d;
  bcd_pair_t    hh_q, hh_d, mm_q, mm_d, ss_q, ss_d;
  logic         pm_q, pm_d, sec_tick_q, sec_tick_d, ringing_q, ringing_d;

  logic         set_ok, alarm_ok, tick, alarm_hit;
  bcd_pair_t    hour_cur, min_cur, sec_cur, hour_nxt, min_nxt, sec_nxt;
  logic         sec_carry, min_carry, day_wrap_unused;

  // An out-of-range load is treated as if the strobe never happened.
  assign set_ok   = set_time && bcd_pair_ok(set_hh, MAX_HOUR) &&
                    bcd_pair_ok(set_mm, MAX_MIN) && bcd_pair_ok(set_ss, MAX_SEC);
  assign alarm_ok = alarm_wr && bcd_pair_ok(alarm_hh, MAX_HOUR) && bcd_pair_ok(alarm_mm, MAX_MIN);
  assign tick     = ena && !set_ok && (presc_q == DIV_LAST);

  bcd_wrap_counter #(.MAX(MAX_SEC)) u_sec (
    .clk(clk), .reset(reset), .inc(tick), .load(set_ok), .load_val(set_ss),
    .q(sec_cur), .nxt(sec_nxt), .carry(sec_carry)
  );

  bcd_wrap_counter #(.MAX(MAX_MIN)) u_min (
    .clk(clk), .reset(reset), .inc(sec_carry), .load(set_ok), .load_val(set_mm),
    .q(min_cur), .nxt(min_nxt), .carry(min_carry)
  );

  bcd_wrap_counter #(.MAX(MAX_HOUR)) u_hour (
    .clk(clk), .reset(reset), .inc(min_carry), .load(set_ok), .load_val(set_hh),
    .q(hour_cur), .nxt(hour_nxt), .carry(day_wrap_unused)
  );

  // The alarm fires on the tick that lands exactly on hh:mm:00.
  assign alarm_hit = tick && (hour_nxt == alarm_hh_q) && (min_nxt == alarm_mm_q) && (sec_nxt == 8'h00);

  always_comb begin
    presc_d    = presc_q;
    alarm_hh_d = alarm_hh_q;
    alarm_mm_d = alarm_mm_q;
    if (set_ok)   presc_d = '0;
    else if (ena) presc_d = (presc_q == DIV_LAST) ? '0 : presc_q + 24'd1;
    if (alarm_ok) begin
      alarm_hh_d = alarm_hh;
      alarm_mm_d = alarm_mm;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    if (!alarm_on) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (alarm_hit) begin
            state_d = RINGING;
            cnt_d   = RING_LD;
          end
        end
        RINGING: begin
          if (stop) begin
            state_d = IDLE;
          end else if (snooze) begin
            state_d = SNOOZED;
            cnt_d   = SNOOZE_LD;
          end else if (tick) begin
            if (cnt_q <= 32'd1) state_d = IDLE;
            else                cnt_d   = cnt_q - 32'd1;
          end
        end
        SNOOZED: begin
          if (stop) begin
            state_d = IDLE;
          end else if (tick) begin
            if (cnt_q <= 32'd1) begin
              state_d = RINGING;
              cnt_d   = RING_LD;
            end else begin
              cnt_d = cnt_q - 32'd1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  // Output stage: everything shown lags the internal update by one edge.
  always_comb begin
    tick_dly_d = tick;
    hh_d       = hour_display(hour_cur, mode24);
    mm_d       = min_cur;
    ss_d       = sec_cur;
    pm_d       = (hour_cur >= 8'h12);
    sec_tick_d = tick_dly_q;
    ringing_d  = (state_q == RINGING);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      presc_q    <= '0;
      alarm_hh_q <= '0;
      alarm_mm_q <= '0;
      state_q    <= IDLE;
      cnt_q      <= '0;
      tick_dly_q <= 1'b0;
      hh_q       <= hour_display(8'h00, mode24);
      mm_q       <= '0;
      ss_q       <= '0;
      pm_q       <= 1'b0;
      sec_tick_q <= 1'b0;
      ringing_q  <= 1'b0;
    end else begin
      presc_q    <= presc_d;
      alarm_hh_q <= alarm_hh_d;
      alarm_mm_q <= alarm_mm_d;
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      tick_dly_q <= tick_dly_d;
      hh_q       <= hh_d;
      mm_q       <= mm_d;
      ss_q       <= ss_d;
      pm_q       <= pm_d;
      sec_tick_q <= sec_tick_d;
      ringing_q  <= ringing_d;
    end
  end

  assign hh       = hh_q;
  assign mm       = mm_q;
  assign ss       = ss_q;
  assign pm       = pm_q;
  assign sec_tick = sec_tick_q;
  assign ringing  = ringing_q;

endmodule

// File: tb/tb_bcd_alarm_clock.sv
// Scoreboard bench: stimulus queues expected displays keyed to sec_tick index or an
// immediate probe; a separate monitor pops and compares them at the falling edge.
module tb_bcd_alarm_clock;

  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       reset, ena, mode24, set_time, alarm_wr, alarm_on, snooze, stop;
  logic [7:0] set_hh, set_mm, set_ss, alarm_hh, alarm_mm;
  logic [7:0] hh, mm, ss;
  logic       pm, sec_tick, ringing;

  always #5 clk = ~clk;

  bcd_alarm_clock #(.CLK_DIV(DIV), .SNOOZE_SEC(300), .RING_SEC(60)) dut (
    .clk(clk), .reset(reset), .ena(ena), .mode24(mode24),
    .set_time(set_time), .set_hh(set_hh), .set_mm(set_mm), .set_ss(set_ss),
    .alarm_wr(alarm_wr), .alarm_hh(alarm_hh), .alarm_mm(alarm_mm), .alarm_on(alarm_on),
    .snooze(snooze), .stop(stop),
    .hh(hh), .mm(mm), .ss(ss), .pm(pm), .sec_tick(sec_tick), .ringing(ringing)
  );

  typedef struct packed {
    logic [95:0] name;
    int          idx;
    bit          is_cnt;
    int          base;
    int          exp_cnt;
    logic [7:0]  hh;
    logic [7:0]  mm;
    logic [7:0]  ss;
    logic        pm;
    logic        ring;
  } exp_t;

  exp_t tq[$];
  exp_t pq[$];
  int   n_checks   = 0;
  int   n_fail     = 0;
  int   ticks_seen = 0;
  logic probe      = 1'b0;
  logic fin        = 1'b0;
  int   base;

  function automatic exp_t mk(input logic [95:0] nm, input int idx, input logic [7:0] h,
                              input logic [7:0] m, input logic [7:0] s, input logic p,
                              input logic r);
    exp_t e;
    e = '0;
    e.name = nm; e.idx = idx; e.hh = h; e.mm = m; e.ss = s; e.pm = p; e.ring = r;
    return e;
  endfunction

  function automatic exp_t mk_cnt(input logic [95:0] nm, input int b, input int n);
    exp_t e;
    e = '0;
    e.name = nm; e.is_cnt = 1'b1; e.base = b; e.exp_cnt = n;
    return e;
  endfunction

  task automatic check(input exp_t e);
    n_checks++;
    if (e.is_cnt) begin
      if (ticks_seen - e.base != e.exp_cnt) begin
        n_fail++;
        $display("FAIL %0s: sec_tick pulses got %0d, want %0d", e.name, ticks_seen - e.base, e.exp_cnt);
      end
    end else if ({hh, mm, ss, pm, ringing} !== {e.hh, e.mm, e.ss, e.pm, e.ring}) begin
      n_fail++;
      $display("FAIL %0s: got %h:%h:%h pm=%b ring=%b, want %h:%h:%h pm=%b ring=%b",
               e.name, hh, mm, ss, pm, ringing, e.hh, e.mm, e.ss, e.pm, e.ring);
    end
  endtask

  // Monitor: owns all counters and the summary line.
  initial begin
    forever begin
      @(negedge clk);
      if (probe) begin
        if (pq.size() == 0) begin
          n_checks++; n_fail++;
          $display("FAIL probe: no expectation queued");
        end else begin
          check(pq.pop_front());
        end
      end
      if (sec_tick === 1'b1) begin
        ticks_seen++;
        while (tq.size() > 0 && tq[0].idx <= ticks_seen) check(tq.pop_front());
      end
      if (fin) begin
        while (tq.size() > 0) begin
          n_checks++; n_fail++;
          $display("FAIL %0s: tick %0d never observed, got %0d ticks", tq[0].name, tq[0].idx, ticks_seen);
          void'(tq.pop_front());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
      end
    end
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached, got no finish, want finish");
    $fatal(1);
  end

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic expect_now(input exp_t e);
    pq.push_back(e);
    probe = 1'b1;
    step(1);
    probe = 1'b0;
  endtask

  task automatic run_ticks(input int n);
    ena = 1'b1;
    step(n * DIV);
    ena = 1'b0;
    step(3);
  endtask

  task automatic load_time(input logic [7:0] h, input logic [7:0] m, input logic [7:0] s);
    set_hh = h; set_mm = m; set_ss = s; set_time = 1'b1;
    step(1);
    set_time = 1'b0;
    step(1);
  endtask

  task automatic write_alarm(input logic [7:0] h, input logic [7:0] m);
    alarm_hh = h; alarm_mm = m; alarm_wr = 1'b1;
    step(1);
    alarm_wr = 1'b0;
  endtask

  task automatic tick_into_ring(input logic [95:0] nm);
    load_time(8'h07, 8'h29, 8'h59);
    base = ticks_seen;
    tq.push_back(mk(nm, base + 1, 8'h07, 8'h30, 8'h00, 1'b0, 1'b1));
    run_ticks(1);
  endtask

  initial begin
    reset = 1'b1; ena = 1'b0; mode24 = 1'b0; set_time = 1'b0; alarm_wr = 1'b0;
    alarm_on = 1'b0; snooze = 1'b0; stop = 1'b0;
    set_hh = '0; set_mm = '0; set_ss = '0; alarm_hh = '0; alarm_mm = '0;
    step(3);
    expect_now(mk("reset_12h", 0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0));
    reset = 1'b0;
    mode24 = 1'b1; step(1);
    expect_now(mk("reset_24h", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    mode24 = 1'b0; step(1);

    // One minute of counting from zero.
    base = ticks_seen;
    tq.push_back(mk("first_sec", base + 1, 8'h12, 8'h00, 8'h01, 1'b0, 1'b0));
    tq.push_back(mk("minute", base + 60, 8'h12, 8'h01, 8'h00, 1'b0, 1'b0));
    run_ticks(60);
    expect_now(mk_cnt("tick_count", base, 60));
    expect_now(mk("after_60s", 0, 8'h12, 8'h01, 8'h00, 1'b0, 1'b0));

    // Noon rollover and display modes.
    load_time(8'h11, 8'h59, 8'h59);
    expect_now(mk("set_115959", 0, 8'h11, 8'h59, 8'h59, 1'b0, 1'b0));
    base = ticks_seen;
    tq.push_back(mk("noon_12h", base + 1, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0));
    run_ticks(1);
    mode24 = 1'b1; step(1);
    expect_now(mk("noon_24h", 0, 8'h12, 8'h00, 8'h00, 1'b1, 1'b0));
    mode24 = 1'b0; step(1);

    load_time(8'h12, 8'h59, 8'h59);
    base = ticks_seen;
    tq.push_back(mk("h13_12h", base + 1, 8'h01, 8'h00, 8'h00, 1'b1, 1'b0));
    run_ticks(1);
    mode24 = 1'b1; step(1);
    expect_now(mk("h13_24h", 0, 8'h13, 8'h00, 8'h00, 1'b1, 1'b0));
    mode24 = 1'b0; step(1);

    load_time(8'h09, 8'h59, 8'h59);
    base = ticks_seen;
    tq.push_back(mk("h10", base + 1, 8'h10, 8'h00, 8'h00, 1'b0, 1'b0));
    run_ticks(1);

    // Midnight rollover.
    load_time(8'h23, 8'h59, 8'h59);
    expect_now(mk("set_235959", 0, 8'h11, 8'h59, 8'h59, 1'b1, 1'b0));
    base = ticks_seen;
    tq.push_back(mk("midnight_12h", base + 1, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0));
    run_ticks(1);
    mode24 = 1'b1; step(1);
    expect_now(mk("midnight_24h", 0, 8'h00, 8'h00, 8'h00, 1'b0, 1'b0));
    mode24 = 1'b0; step(1);

    // Out-of-range loads leave the time alone.
    load_time(8'h08, 8'h6A, 8'h00);
    expect_now(mk("bad_min", 0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0));
    load_time(8'h24, 8'h00, 8'h00);
    expect_now(mk("bad_hour", 0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0));

    // Alarm 07:30 (the later 07:60 write must be ignored), automatic stop.
    write_alarm(8'h07, 8'h30);
    write_alarm(8'h07, 8'h60);
    alarm_on = 1'b1;
    load_time(8'h07, 8'h29, 8'h59);
    expect_now(mk("pre_alarm", 0, 8'h07, 8'h29, 8'h59, 1'b0, 1'b0));
    base = ticks_seen;
    tq.push_back(mk("ring_start", base + 1, 8'h07, 8'h30, 8'h00, 1'b0, 1'b1));
    tq.push_back(mk("ring_60", base + 60, 8'h07, 8'h30, 8'h59, 1'b0, 1'b1));
    tq.push_back(mk("ring_autooff", base + 61, 8'h07, 8'h31, 8'h00, 1'b0, 1'b0));
    run_ticks(61);

    // Snooze, re-ring after 300 s, then stop+snooze together lands in IDLE.
    tick_into_ring("ring_again");
    snooze = 1'b1; step(1); snooze = 1'b0; step(1);
    expect_now(mk("snoozed", 0, 8'h07, 8'h30, 8'h00, 1'b0, 1'b0));
    base = ticks_seen;
    tq.push_back(mk("snooze_299", base + 299, 8'h07, 8'h34, 8'h59, 1'b0, 1'b0));
    tq.push_back(mk("snooze_ring", base + 300, 8'h07, 8'h35, 8'h00, 1'b0, 1'b1));
    run_ticks(300);
    stop = 1'b1; snooze = 1'b1; step(1); stop = 1'b0; snooze = 1'b0; step(1);
    expect_now(mk("stop_snooze", 0, 8'h07, 8'h35, 8'h00, 1'b0, 1'b0));
    base = ticks_seen;
    tq.push_back(mk("stays_idle", base + 300, 8'h07, 8'h40, 8'h00, 1'b0, 1'b0));
    run_ticks(300);

    // Disarming silences a ringing alarm.
    tick_into_ring("ring_3");
    alarm_on = 1'b0; step(2);
    expect_now(mk("alarm_off", 0, 8'h07, 8'h30, 8'h00, 1'b0, 1'b0));
    alarm_on = 1'b1;

    // Reset mid-ring, with a competing valid load on the same edge.
    tick_into_ring("ring_4");
    set_hh = 8'h05; set_mm = 8'h05; set_ss = 8'h05; set_time = 1'b1;
    reset = 1'b1; step(1);
    set_time = 1'b0;
    expect_now(mk("reset_ring", 0, 8'h12, 8'h00, 8'h00, 1'b0, 1'b0));
    reset = 1'b0;
    step(2);

    fin = 1'b1;
    step(4);
  end

endmodule

// File: doc/bcd_alarm_clock.md
BCD_ALARM_CLOCK -- requirements
Module: bcd_alarm_clock

Interface
REQ-001 SHALL have parameter CLK_DIV, default 1: clk cycles per one-second tick, range 1..2^24.
REQ-002 SHALL have parameter SNOOZE_SEC, default 300: seconds from a snooze request until the alarm re-rings.
REQ-003 SHALL have parameter RING_SEC, default 60: seconds of ringing before automatic stop.
REQ-004 SHALL have port clk, input, 1: single clock, rising edge.
REQ-005 SHALL have port reset, input, 1: reset, synchronous, active-high.
REQ-006 SHALL have port ena, input, 1: prescaler and timekeeping enable.
REQ-007 SHALL have port mode24, input, 1: display format, 1 = 24 h, 0 = 12 h; affects outputs only.
REQ-008 SHALL have port set_time, input, 1: load pulse for set_hh/set_mm/set_ss.
REQ-009 SHALL have ports set_hh, set_mm, set_ss, input, 8 each: BCD load values, hours in 24 h form (00-23).
REQ-010 SHALL have port alarm_wr, input, 1: load pulse for alarm_hh/alarm_mm.
REQ-011 SHALL have ports alarm_hh, alarm_mm, input, 8 each: BCD alarm time, 24 h form.
REQ-012 SHALL have port alarm_on, input, 1: alarm arm level.
REQ-013 SHALL have ports snooze and stop, input, 1 each: user requests, sampled each cycle.
REQ-014 SHALL have ports hh, mm, ss, output, 8 each: BCD time, tens digit in [7:4], units in [3:0].
REQ-015 SHALL have port pm, output, 1: 1 when the internal hour is 12-23, in both modes.
REQ-016 SHALL have port sec_tick, output, 1: one-cycle pulse on each second increment.
REQ-017 SHALL have port ringing, output, 1: alarm active.

Function
REQ-018 SHALL hold time internally as 24 h BCD; prescaler counts 0..CLK_DIV-1 only while ena=1; tick asserts on the cycle the count equals CLK_DIV-1, and the counter wraps to 0.
REQ-019 SHALL, on tick, increment ss; carries: ss 59->00 increments mm; mm 59->00 increments the hour; hour 23->00 with no day output; all updated on the same edge.
REQ-020 SHALL drive registered outputs with latency 1 cycle after the increment edge; sec_tick aligns with the updated ss.
REQ-021 SHALL, in 12 h mode, map hour 00->12, 01-12 unchanged, 13-23->01-11; in 24 h mode output the hour unchanged; a mode24 change takes effect on the next cycle with no time loss.
REQ-022 SHALL, on set_time=1, load the time, reset the prescaler to 0, and suppress that cycle's tick; set_time has priority over tick.
REQ-023 SHALL ignore a set_time or alarm_wr whose value has a digit >9, hour >23, or minute/second >59, leaving state unchanged.
REQ-024 SHALL implement alarm FSM states IDLE, RINGING, SNOOZED; ringing=1 only in RINGING.
REQ-025 SHALL move IDLE->RINGING on the tick that makes the time equal alarm_hh:alarm_mm:00 while alarm_on=1.
REQ-026 SHALL, in RINGING: on stop go to IDLE; else on snooze go to SNOOZED and load the countdown with SNOOZE_SEC; else after RING_SEC ticks go to IDLE.
REQ-027 SHALL, in SNOOZED, decrement the countdown per tick and go to RINGING at 0; on stop go to IDLE.
REQ-028 SHALL give stop priority over snooze when both are high; alarm_on=0 forces IDLE from any state on the next edge.
REQ-029 SHALL not advance the RING_SEC or snooze countdowns while ena=0.

Reset
REQ-030 SHALL, on reset, clear the time to 00:00:00 internal (outputs hh=12 pm=0 in 12 h mode, hh=00 in 24 h mode), clear the prescaler, clear the alarm registers to 00:00, set the FSM to IDLE, and drive sec_tick=0 and ringing=0; reset overrides all other inputs, including mid-ring.

Structure
REQ-031 SHALL place the alarm state enum, BCD digit/pair typedefs, and limit constants (59, 23) in shared package clock_pkg.
REQ-032 SHALL implement the ss, mm and hour pairs with one sub-module, bcd_wrap_counter (parameter MAX, inc and load in, carry out), instantiated three times.

Verification
REQ-033 SHALL cover: CLK_DIV=4, reset, then ena=1 for 4*60 cycles -> mm=01 ss=00, exactly 60 sec_tick pulses.
REQ-034 SHALL cover: set_time 11:59:59, mode24=0, one tick -> hh=12 mm=00 ss=00 pm=1; then mode24=1 -> hh=12.
REQ-035 SHALL cover: set_time 23:59:59, one tick -> internal 00:00:00, 12 h output 12:00:00 pm=0.
REQ-036 SHALL cover: alarm 07:30, alarm_on=1, time 07:29:59, tick -> ringing=1; no input for 60 ticks -> ringing=0.
REQ-037 SHALL cover: ringing, snooze with SNOOZE_SEC=300 -> ringing=0; 300 ticks later ringing=1; stop and snooze asserted together -> IDLE.
REQ-038 SHALL cover: set_time with set_mm=8'h6A -> time unchanged; reset asserted while ringing -> ringing=0 and hh=12 on the next cycle.
